p5_controller: RTL and testbench
================================

P5_CONTROLLER -- requirements
Module: p5_controller

Interface
REQ-001 HALT_ON_ILLEGAL, 1, undefined opcode/op enters HALT; 0 returns to IF1 as a no-op.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  3  IR[15:13] from the instruction decoder.
REQ-005 op  input  2  IR[12:11] from the instruction decoder.
REQ-006 nsel  output  3  register select, one-hot: 100 Rn, 010 Rd, 001 Rm, 000 none.
REQ-007 write  output  1  register-file write enable.
REQ-008 loada  output  1  load pipeline register A.
REQ-009 loadb  output  1  load pipeline register B.
REQ-010 loadc  output  1  load result register C.
REQ-011 loads  output  1  load status flags N/V/Z.
REQ-012 asel  output  1  1 forces ALU A operand to zero.
REQ-013 bsel  output  1  1 selects sximm5 as ALU B operand.
REQ-014 vsel  output  2  writeback source: 00 C (fed back as datapath_in), 01 sximm8, 10 mdata, 11 PC.
REQ-015 load_ir  output  1  load instruction register.
REQ-016 load_pc  output  1  load program counter.
REQ-017 reset_pc  output  1  next PC = 0 instead of PC+1.
REQ-018 addr_sel  output  1  memory address = PC (1) or data address register (0).
REQ-019 load_addr  output  1  load data address register from C.
REQ-020 mem_cmd  output  2  00 NONE, 01 READ, 10 WRITE.
REQ-021 halted  output  1  high only in HALT.
REQ-022 state  output  5  current state encoding, for debug.

Function
REQ-023 Moore FSM; every output SHALL be a function of the current state only, except the DECODE branch.
- Any output not listed for a state SHALL be 0.
REQ-024 Fetch sequence, one cycle per state:
- RST: reset_pc=1, load_pc=1.
- IF1: addr_sel=1, mem_cmd=READ.
- IF2: addr_sel=1, mem_cmd=READ, load_ir=1.
- UPDATE_PC: load_pc=1.
- Then DECODE (no outputs).
REQ-025 DECODE branches:
- 110/10 (MOV imm) -> WRITE_IMM.
- 110/00 (MOV reg) and 101/11 (MVN) -> GET_B.
- 101/00, 101/01, 101/10 (ADD, CMP, AND) -> GET_A.
- 011/00 (LDR) and 100/00 (STR) -> GET_A.
- 111/xx -> HALT.
- Any other code -> per HALT_ON_ILLEGAL.
REQ-026 WRITE_IMM: nsel=Rn, vsel=01, write=1 -> IF1.
REQ-027 GET_A: nsel=Rn, loada=1 -> GET_B for ALU ops; -> ADDR_CALC for LDR/STR.
REQ-028 GET_B: nsel=Rm, loadb=1 -> ALU.
REQ-029 ALU state:
- asel=1 for MOV reg/MVN; loadc=1 except CMP.
- CMP: loads=1, loadc=0, -> IF1.
- All others -> WRITE_REG.
REQ-030 WRITE_REG: nsel=Rd, vsel=00, write=1 -> IF1.
REQ-031 ADDR_CALC: bsel=1, loadc=1 -> LOAD_ADDR; LOAD_ADDR: load_addr=1 -> MEM_RD (LDR) or GET_RD (STR).
REQ-032 LDR path:
- MEM_RD: addr_sel=0, mem_cmd=READ.
- WB_MEM: mem_cmd=READ, nsel=Rd, vsel=10, write=1 -> IF1.
REQ-033 STR path:
- GET_RD: nsel=Rd, loadb=1.
- STR_C: asel=1, loadc=1.
- MEM_WR: addr_sel=0, mem_cmd=WRITE -> IF1.
REQ-034 Latency from IF1 to next IF1:
- MOV imm: 5 cycles.
- CMP: 7 cycles.
- ADD/AND: 8 cycles.
- MOV reg/MVN: 7 cycles.
- LDR: 9 cycles.
- STR: 10 cycles.
REQ-035 HALT SHALL hold with halted=1 and no memory or register activity until reset.
REQ-036 opcode/op SHALL be sampled only in DECODE and the branch states that follow; IR changes outside DECODE SHALL NOT alter the current path.

Reset
REQ-037 reset SHALL force state RST immediately, including mid-instruction; with reset high, reset_pc=1, load_pc=1, state=RST encoding, and all other outputs 0.
REQ-038 The first rising clk after reset deasserts SHALL move the FSM to IF1.

Structure
REQ-039 Package p5_ctrl_pkg SHALL hold the state, opcode/op, mem_cmd, vsel and nsel constants; the datapath and memory top SHALL import mem_cmd and vsel from it.
REQ-040 One combinational sub-module, p5_ctrl_outdec (state -> output vector), is natural; the next-state logic stays in p5_controller.

Verification
REQ-041 Reset held 3 cycles, released -> RST (reset_pc=1, load_pc=1) then IF1 with mem_cmd=01, addr_sel=1.
REQ-042 opcode 110, op 10 -> IF1, IF2, UPDATE_PC, DECODE, WRITE_IMM with nsel=100, vsel=01, write=1; back in IF1 after 5 cycles.
REQ-043 opcode 101, op 01 (CMP) -> loads=1 and loadc=0 in ALU state, write never asserted, IF1 after 7 cycles.
REQ-044 LDR (011/00) -> bsel=1 in ADDR_CALC, addr_sel=0 with mem_cmd=01 in MEM_RD, vsel=10 with write=1 in WB_MEM; STR (100/00) -> mem_cmd=10 exactly one cycle.
REQ-045 opcode 111 -> halted=1 held 20 cycles with mem_cmd=00; reset asserted in GET_B of an ADD -> state=RST same cycle, no write issued.

Source files
------------

// File: rtl/p5_ctrl_pkg.sv
// Shared constants and types for the P5 instruction-sequencing controller.
package p5_ctrl_pkg;

  // Controller state encoding (also exported on the debug state port).
  typedef enum logic [4:0] {
    S_RST       = 5'd0,
    S_IF1       = 5'd1,
    S_IF2       = 5'd2,
    S_UPDATE_PC = 5'd3,
    S_DECODE    = 5'd4,
    S_WRITE_IMM = 5'd5,
    S_GET_A     = 5'd6,
    S_GET_B     = 5'd7,
    S_ALU       = 5'd8,
    S_ALU_CMP   = 5'd9,
    S_ALU_MOV   = 5'd10,
    S_WRITE_REG = 5'd11,
    S_ADDR_CALC = 5'd12,
    S_LOAD_ADDR = 5'd13,
    S_MEM_RD    = 5'd14,
    S_WB_MEM    = 5'd15,
    S_GET_RD    = 5'd16,
    S_STR_C     = 5'd17,
    S_MEM_WR    = 5'd18,
    S_HALT      = 5'd19
  } state_e;

  // Instruction class captured in DECODE; steers the later branch states.
  typedef enum logic [2:0] {
    K_ALU  = 3'd0,   // ADD, AND
    K_CMP  = 3'd1,
    K_MOVR = 3'd2,   // MOV reg, MVN
    K_LDR  = 3'd3,
    K_STR  = 3'd4
  } cls_e;

  // Opcode field IR[15:13]
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // Op field IR[12:11]
  localparam logic [1:0] OP_00 = 2'b00;
  localparam logic [1:0] OP_01 = 2'b01;
  localparam logic [1:0] OP_10 = 2'b10;
  localparam logic [1:0] OP_11 = 2'b11;

  // Memory command
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Writeback source
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

  // Register select (one-hot)
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  // Full control word, MSB first in port order.
  typedef struct packed {
    logic [2:0] nsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/p5_ctrl_outdec.sv
// Pure state -> control-word decoder (Moore outputs of the controller).
module p5_ctrl_outdec
  import p5_ctrl_pkg::*;
(
  input  logic [4:0]        i_state,
  output logic [CTRL_W-1:0] o_ctrl
);

  ctrl_t w_c;

  // Everything defaults to 0; each state raises only its own strobes.
  always_comb begin
    w_c = '0;
    case (state_e'(i_state))
      S_RST:       begin w_c.reset_pc = 1'b1; w_c.load_pc = 1'b1; end
      S_IF1:       begin w_c.addr_sel = 1'b1; w_c.mem_cmd = MEM_READ; end
      S_IF2:       begin w_c.addr_sel = 1'b1; w_c.mem_cmd = MEM_READ; w_c.load_ir = 1'b1; end
      S_UPDATE_PC: w_c.load_pc = 1'b1;
      S_WRITE_IMM: begin w_c.nsel = NSEL_RN; w_c.vsel = VSEL_IMM8; w_c.write = 1'b1; end
      S_GET_A:     begin w_c.nsel = NSEL_RN; w_c.loada = 1'b1; end
      S_GET_B:     begin w_c.nsel = NSEL_RM; w_c.loadb = 1'b1; end
      S_ALU:       w_c.loadc = 1'b1;
      S_ALU_CMP:   w_c.loads = 1'b1;
      S_ALU_MOV:   begin w_c.asel = 1'b1; w_c.loadc = 1'b1; end
      S_WRITE_REG: begin w_c.nsel = NSEL_RD; w_c.vsel = VSEL_C; w_c.write = 1'b1; end
      S_ADDR_CALC: begin w_c.bsel = 1'b1; w_c.loadc = 1'b1; end
      S_LOAD_ADDR: w_c.load_addr = 1'b1;
      S_MEM_RD:    w_c.mem_cmd = MEM_READ;
      S_WB_MEM:    begin
        w_c.mem_cmd = MEM_READ; w_c.nsel = NSEL_RD; w_c.vsel = VSEL_MDATA; w_c.write = 1'b1;
      end
      S_GET_RD:    begin w_c.nsel = NSEL_RD; w_c.loadb = 1'b1; end
      S_STR_C:     begin w_c.asel = 1'b1; w_c.loadc = 1'b1; end
      S_MEM_WR:    w_c.mem_cmd = MEM_WRITE;
      S_HALT:      w_c.halted = 1'b1;
      default:     w_c = '0;
    endcase
  end

  assign o_ctrl = w_c;

endmodule

// File: rtl/p5_controller.sv
// P5 instruction sequencer: fetch, decode and per-instruction execute FSM.
// The ALU step is split into three states so its strobes stay Moore; the
// instruction class is captured in DECODE so later IR changes are ignored.
module p5_controller
  import p5_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic [4:0] state
);

  state_e            r_state, w_next;
  cls_e              r_cls, w_cls_next;
  logic [CTRL_W-1:0] w_ctrl;

  // State and captured instruction class.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RST;
      r_cls   <= K_ALU;
    end else begin
      r_state <= w_next;
      r_cls   <= w_cls_next;
    end
  end

  // Next-state: IR is looked at only in DECODE; later branches use r_cls.
  always_comb begin
    w_next     = r_state;
    w_cls_next = r_cls;
    case (r_state)
      S_RST:       w_next = S_IF1;
      S_IF1:       w_next = S_IF2;
      S_IF2:       w_next = S_UPDATE_PC;
      S_UPDATE_PC: w_next = S_DECODE;
      S_DECODE: begin
        case ({opcode, op})
          {OPC_MOV, OP_10}:                   w_next = S_WRITE_IMM;
          {OPC_MOV, OP_00}, {OPC_ALU, OP_11}: begin w_next = S_GET_B; w_cls_next = K_MOVR; end
          {OPC_ALU, OP_00}, {OPC_ALU, OP_10}: begin w_next = S_GET_A; w_cls_next = K_ALU;  end
          {OPC_ALU, OP_01}:                   begin w_next = S_GET_A; w_cls_next = K_CMP;  end
          {OPC_LDR, OP_00}:                   begin w_next = S_GET_A; w_cls_next = K_LDR;  end
          {OPC_STR, OP_00}:                   begin w_next = S_GET_A; w_cls_next = K_STR;  end
          default:
            w_next = (opcode == OPC_HALT || HALT_ON_ILLEGAL) ? S_HALT : S_IF1;
        endcase
      end
      S_WRITE_IMM: w_next = S_IF1;
      S_GET_A:     w_next = (r_cls == K_LDR || r_cls == K_STR) ? S_ADDR_CALC : S_GET_B;
      S_GET_B: begin
        case (r_cls)
          K_CMP:   w_next = S_ALU_CMP;
          K_MOVR:  w_next = S_ALU_MOV;
          default: w_next = S_ALU;
        endcase
      end
      S_ALU, S_ALU_MOV: w_next = S_WRITE_REG;
      S_ALU_CMP:   w_next = S_IF1;
      S_WRITE_REG: w_next = S_IF1;
      S_ADDR_CALC: w_next = S_LOAD_ADDR;
      S_LOAD_ADDR: w_next = (r_cls == K_LDR) ? S_MEM_RD : S_GET_RD;
      S_MEM_RD:    w_next = S_WB_MEM;
      S_WB_MEM:    w_next = S_IF1;
      S_GET_RD:    w_next = S_STR_C;
      S_STR_C:     w_next = S_MEM_WR;
      S_MEM_WR:    w_next = S_IF1;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_RST;
    endcase
  end

  p5_ctrl_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign {nsel, write, loada, loadb, loadc, loads, asel, bsel, vsel, load_ir,
          load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted} = w_ctrl;
  assign state = r_state;

endmodule

// File: tb/tb_p5_controller.sv
// Randomized instruction stream against a step-list model of the controller.
module tb_p5_controller;
  import p5_ctrl_pkg::*;

  localparam bit HOI = 1'b0;   // illegal codes act as a no-op in this bench

  // Abstract steps of an instruction, independent of the RTL encoding.
  typedef enum int {
    T_RST, T_IF1, T_IF2, T_UPC, T_DEC, T_WIMM, T_GETA, T_GETB, T_ALU_C,
    T_ALU_S, T_ALU_Z, T_WREG, T_ACALC, T_LADDR, T_MRD, T_WBM, T_GETRD,
    T_STRC, T_MWR, T_HALT
  } step_e;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] nsel;
  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
  logic [1:0] mem_cmd;
  logic       halted;
  logic [4:0] state;

  p5_controller #(.HALT_ON_ILLEGAL(HOI)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .nsel(nsel),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // Observed word: nsel,write,loada,loadb,loadc,loads,asel,bsel,vsel,
  // load_ir,load_pc,reset_pc,addr_sel,load_addr,mem_cmd,halted
  logic [19:0] dv;
  assign dv = {nsel, write, loada, loadb, loadc, loads, asel, bsel, vsel,
               load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

  // Required word for each step, written straight from the output tables.
  function automatic logic [19:0] vec_of(step_e t);
    logic [2:0] n; logic w, la, lb, lc, ls, as, bs, lir, lpc, rpc, ads, lad, h;
    logic [1:0] vs, mc;
    {n, w, la, lb, lc, ls, as, bs, vs, lir, lpc, rpc, ads, lad, mc, h} = '0;
    case (t)
      T_RST:   begin rpc = 1; lpc = 1; end
      T_IF1:   begin ads = 1; mc = 2'b01; end
      T_IF2:   begin ads = 1; mc = 2'b01; lir = 1; end
      T_UPC:   lpc = 1;
      T_WIMM:  begin n = 3'b100; vs = 2'b01; w = 1; end
      T_GETA:  begin n = 3'b100; la = 1; end
      T_GETB:  begin n = 3'b001; lb = 1; end
      T_ALU_C: lc = 1;
      T_ALU_S: ls = 1;
      T_ALU_Z: begin as = 1; lc = 1; end
      T_WREG:  begin n = 3'b010; vs = 2'b00; w = 1; end
      T_ACALC: begin bs = 1; lc = 1; end
      T_LADDR: lad = 1;
      T_MRD:   mc = 2'b01;
      T_WBM:   begin mc = 2'b01; n = 3'b010; vs = 2'b10; w = 1; end
      T_GETRD: begin n = 3'b010; lb = 1; end
      T_STRC:  begin as = 1; lc = 1; end
      T_MWR:   mc = 2'b10;
      T_HALT:  h = 1;
      default: ;
    endcase
    return {n, w, la, lb, lc, ls, as, bs, vs, lir, lpc, rpc, ads, lad, mc, h};
  endfunction

  // Hand-written IF1-to-IF1 latencies; 0 means the instruction never returns.
  function automatic int lat_lit(logic [4:0] c);
    case (c)
      5'b110_10:            return 5;
      5'b110_00, 5'b101_11: return 7;
      5'b101_01:            return 7;
      5'b101_00, 5'b101_10: return 8;
      5'b011_00:            return 9;
      5'b100_00:            return 10;
      default:              return (c[4:2] == 3'b111 || HOI) ? 0 : 4;
    endcase
  endfunction

  step_e exp_q[$];
  bit    halt_exp;

  // Execute-phase step list for one instruction.
  task automatic plan(input logic [4:0] c);
    exp_q.delete();
    halt_exp = 0;
    if (c == 5'b110_10) exp_q.push_back(T_WIMM);
    else if (c == 5'b110_00 || c == 5'b101_11) exp_q = '{T_GETB, T_ALU_Z, T_WREG};
    else if (c == 5'b101_01) exp_q = '{T_GETA, T_GETB, T_ALU_S};
    else if (c[4:2] == 3'b101) exp_q = '{T_GETA, T_GETB, T_ALU_C, T_WREG};
    else if (c == 5'b011_00) exp_q = '{T_GETA, T_ACALC, T_LADDR, T_MRD, T_WBM};
    else if (c == 5'b100_00) exp_q = '{T_GETA, T_ACALC, T_LADDR, T_GETRD, T_STRC, T_MWR};
    else if (c[4:2] == 3'b111 || HOI) halt_exp = 1;
  endtask

  int    vectors = 0, miscompares = 0;
  bit    chk_en = 0;
  step_e exp_step = T_RST;
  int    lat_exp = 0;
  int    since = 0;

  // Per-cycle compare against the current expected step, plus DUT-measured latency.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (dv !== vec_of(exp_step)) begin
        miscompares++;
        $display("FAIL ctrl[%s] t=%0t got=%b exp=%b", exp_step.name(), $time, dv, vec_of(exp_step));
      end
      if (exp_step == T_RST || exp_step == T_IF1) begin
        vectors++;
        if (state !== (exp_step == T_RST ? 5'(S_RST) : 5'(S_IF1))) begin
          miscompares++;
          $display("FAIL state[%s] got=%0d", exp_step.name(), state);
        end
      end
      since++;
      if (state == 5'(S_IF1)) begin
        if (lat_exp != 0) begin
          vectors++;
          if (since != lat_exp) begin
            miscompares++;
            $display("FAIL latency got=%0d exp=%0d", since, lat_exp);
          end
        end
        since = 0;
      end
    end
  end

  task automatic cyc(input step_e t, input bit fix, input logic [4:0] c);
    @(posedge clk); #1;
    exp_step = t;
    if (fix) {opcode, op} = c;
    else {opcode, op} = 5'($urandom);
  endtask

  // Asynchronous reset: must reach RST within the same cycle.
  task automatic do_reset(input int n);
    lat_exp = 0;
    exp_step = T_RST;
    reset = 1'b1;
    #1;
    vectors++;
    if (state !== 5'(S_RST) || write !== 1'b0 || reset_pc !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset state=%0d write=%b reset_pc=%b", state, write, reset_pc);
    end
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [4:0] table5 [0:8] = '{5'b110_10, 5'b110_00, 5'b101_11, 5'b101_00,
                               5'b101_01, 5'b101_10, 5'b011_00, 5'b100_00, 5'b111_00};

  initial begin
    chk_en = 1;
    do_reset(3);
    for (int n = 0; n < 260; n++) begin
      logic [4:0] c;
      bit mid;
      mid = (n % 29 == 28);
      if (mid) c = 5'b101_00;
      else if (n < 9) c = table5[n];
      else if ($urandom_range(0, 9) < 8) c = table5[$urandom_range(0, 7)];
      else c = 5'($urandom);
      cyc(T_IF1, 0, 5'd0);
      cyc(T_IF2, 0, 5'd0);
      cyc(T_UPC, 0, 5'd0);
      cyc(T_DEC, 1, c);
      plan(c);
      lat_exp = lat_lit(c);
      foreach (exp_q[i]) begin
        cyc(exp_q[i], 0, 5'd0);
        if (mid && exp_q[i] == T_GETB) begin
          @(negedge clk); #1;
          do_reset(2);
          break;
        end
      end
      if (halt_exp) begin
        repeat (20) cyc(T_HALT, 0, 5'd0);
        do_reset(1 + $urandom_range(0, 2));
      end
    end
    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
